// File: rtl/bp_be_fp_to_rec_pipe_if.sv
// Valid/ready bundle between the FP register-file read and the raw-to-recoded pipe.
// Optional macro BP_FP_TO_REC_CLASS_EN adds the fclass result next to the recoded value.
interface bp_be_fp_to_rec_pipe_if;
    localparam int unsigned raw_width_lp   = 64;
    localparam int unsigned rec_width_lp   = 65;
    localparam int unsigned class_width_lp = 10;

    logic [raw_width_lp-1:0]   raw_i;
    logic                      raw_sp_not_dp_i;
    logic                      v_i;
    logic                      ready_o;
    logic [rec_width_lp-1:0]   rec_o;
    logic                      unboxed_o;
    logic                      v_o;
    logic                      yumi_i;
`ifdef BP_FP_TO_REC_CLASS_EN
    logic [class_width_lp-1:0] class_o;
`endif

    modport master (
        output raw_i, raw_sp_not_dp_i, v_i, yumi_i,
        input  ready_o, rec_o, unboxed_o, v_o
`ifdef BP_FP_TO_REC_CLASS_EN
        , input class_o
`endif
    );

    modport slave (
        input  raw_i, raw_sp_not_dp_i, v_i, yumi_i,
        output ready_o, rec_o, unboxed_o, v_o
`ifdef BP_FP_TO_REC_CLASS_EN
        , output class_o
`endif
    );
endinterface

// File: rtl/bp_be_fp_to_rec_pipe.sv
// Two-stage pipe: NaN-box check on capture, then raw IEEE SP/DP -> 65-bit DP-recoded HardFloat.
// Optional macro BP_FP_TO_REC_CLASS_EN adds a registered RISC-V fclass output.
module bp_be_fp_to_rec_pipe (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_be_fp_to_rec_pipe_if.slave bus
);
    localparam int unsigned dword_width_lp = 64;
    localparam int unsigned dp_rec_width_lp = 65;
    localparam int unsigned class_width_lp = 10;
    localparam logic [31:0] sp_canonical_nan_lp = 32'h7FC0_0000;

    // Raw SP (e=8, s=24) to 33-bit SP-recoded
    function automatic logic [32:0] rec_sp(input logic [31:0] f_in);
        logic [7:0]  exp_in;
        logic [22:0] fract_in;
        logic [4:0]  norm_dist;
        logic [22:0] sub_fract;
        logic [8:0]  adj_exp;
        logic [8:0]  exp_out;
        logic        is_zero_exp;
        logic        is_zero_fract;
        exp_in        = f_in[30:23];
        fract_in      = f_in[22:0];
        is_zero_exp   = (exp_in == 8'd0);
        is_zero_fract = (fract_in == 23'd0);
        norm_dist     = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (fract_in[i]) norm_dist = 5'(22 - i);
        end
        sub_fract = 23'({fract_in, 1'b0} << norm_dist);
        adj_exp   = (is_zero_exp ? {4'hF, ~norm_dist} : {1'b0, exp_in})
                  + (is_zero_exp ? 9'd130 : 9'd129);
        if (is_zero_exp && is_zero_fract)  exp_out = 9'd0;
        else if (adj_exp[8:7] == 2'b11)    exp_out = {2'b11, ~is_zero_fract, adj_exp[5:0]};
        else                               exp_out = adj_exp;
        return {f_in[31], exp_out, (is_zero_exp ? sub_fract : fract_in)};
    endfunction

    // Raw DP (e=11, s=53) to 65-bit DP-recoded
    function automatic logic [64:0] rec_dp(input logic [63:0] f_in);
        logic [10:0] exp_in;
        logic [51:0] fract_in;
        logic [5:0]  norm_dist;
        logic [51:0] sub_fract;
        logic [11:0] adj_exp;
        logic [11:0] exp_out;
        logic        is_zero_exp;
        logic        is_zero_fract;
        exp_in        = f_in[62:52];
        fract_in      = f_in[51:0];
        is_zero_exp   = (exp_in == 11'd0);
        is_zero_fract = (fract_in == 52'd0);
        norm_dist     = 6'd0;
        for (int i = 0; i < 52; i++) begin
            if (fract_in[i]) norm_dist = 6'(51 - i);
        end
        sub_fract = 52'({fract_in, 1'b0} << norm_dist);
        adj_exp   = (is_zero_exp ? {6'h3F, ~norm_dist} : {1'b0, exp_in})
                  + (is_zero_exp ? 12'd1026 : 12'd1025);
        if (is_zero_exp && is_zero_fract)  exp_out = 12'd0;
        else if (adj_exp[11:10] == 2'b11)  exp_out = {2'b11, ~is_zero_fract, adj_exp[8:0]};
        else                               exp_out = adj_exp;
        return {f_in[63], exp_out, (is_zero_exp ? sub_fract : fract_in)};
    endfunction

    // SP-recoded to DP-recoded; special codes keep their code bits, the rest rebias
    function automatic logic [64:0] widen_sp_rec(input logic [32:0] sp_rec);
        logic [8:0]  e;
        logic [2:0]  code;
        logic [11:0] dp_exp;
        e    = sp_rec[31:23];
        code = e[8:6];
        if (code == 3'b000 || code >= 3'b110) dp_exp = {code, 3'b000, e[5:0]};
        else                                  dp_exp = {3'b000, e} + 12'd1792;
        return {sp_rec[32], dp_exp, sp_rec[22:0], 29'd0};
    endfunction

`ifdef BP_FP_TO_REC_CLASS_EN
    function automatic logic [9:0] fclass(input logic [63:0] op, input logic sp);
        logic sign, exp_max, exp_zero, fract_zero, quiet;
        logic [9:0] c;
        if (sp) begin
            sign = op[31]; exp_max = &op[30:23]; exp_zero = ~|op[30:23];
            fract_zero = ~|op[22:0]; quiet = op[22];
        end else begin
            sign = op[63]; exp_max = &op[62:52]; exp_zero = ~|op[62:52];
            fract_zero = ~|op[51:0]; quiet = op[51];
        end
        c = 10'd0;
        if (exp_max && !fract_zero)  c[quiet ? 9 : 8] = 1'b1;
        else if (exp_max)            c[sign ? 0 : 7] = 1'b1;
        else if (exp_zero && fract_zero) c[sign ? 3 : 4] = 1'b1;
        else if (exp_zero)           c[sign ? 2 : 5] = 1'b1;
        else                         c[sign ? 1 : 6] = 1'b1;
        return c;
    endfunction
`endif

    logic                       s1_v_q, s1_v_d;
    logic [dword_width_lp-1:0]  s1_op_q, s1_op_d;
    logic                       s1_sp_q, s1_sp_d;
    logic                       s1_unboxed_q, s1_unboxed_d;
    logic                       s2_v_q, s2_v_d;
    logic [dp_rec_width_lp-1:0] s2_rec_q, s2_rec_d;
    logic                       s2_unboxed_q, s2_unboxed_d;
`ifdef BP_FP_TO_REC_CLASS_EN
    logic [class_width_lp-1:0]  s2_class_q, s2_class_d;
`endif

    logic                       ready;
    logic                       in_fire;
    logic                       s2_load;
    logic                       boxed;
    logic [dp_rec_width_lp-1:0] rec_c;

    assign ready   = ~s1_v_q | ~s2_v_q | bus.yumi_i;
    assign in_fire = bus.v_i & ready;
    assign s2_load = s1_v_q & (~s2_v_q | bus.yumi_i);
    assign boxed   = &bus.raw_i[63:32];
    assign rec_c   = s1_sp_q ? widen_sp_rec(rec_sp(s1_op_q[31:0])) : rec_dp(s1_op_q);

    // Next-state for both stages; everything holds unless a stage advances
    always_comb begin
        s1_v_d       = s1_v_q;
        s1_op_d      = s1_op_q;
        s1_sp_d      = s1_sp_q;
        s1_unboxed_d = s1_unboxed_q;
        s2_v_d       = s2_v_q;
        s2_rec_d     = s2_rec_q;
        s2_unboxed_d = s2_unboxed_q;
`ifdef BP_FP_TO_REC_CLASS_EN
        s2_class_d   = s2_class_q;
`endif
        if (in_fire) begin
            s1_v_d       = 1'b1;
            s1_sp_d      = bus.raw_sp_not_dp_i;
            s1_unboxed_d = bus.raw_sp_not_dp_i & ~boxed;
            s1_op_d      = (bus.raw_sp_not_dp_i & ~boxed)
                         ? {32'hFFFF_FFFF, sp_canonical_nan_lp} : bus.raw_i;
        end else if (s2_load) begin
            s1_v_d = 1'b0;
        end

        if (s2_load) begin
            s2_v_d       = 1'b1;
            s2_rec_d     = rec_c;
            s2_unboxed_d = s1_unboxed_q;
`ifdef BP_FP_TO_REC_CLASS_EN
            s2_class_d   = fclass(s1_op_q, s1_sp_q);
`endif
        end else if (bus.yumi_i) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v_q       <= 1'b0;
            s1_op_q      <= '0;
            s1_sp_q      <= 1'b0;
            s1_unboxed_q <= 1'b0;
            s2_v_q       <= 1'b0;
            s2_rec_q     <= '0;
            s2_unboxed_q <= 1'b0;
`ifdef BP_FP_TO_REC_CLASS_EN
            s2_class_q   <= '0;
`endif
        end else begin
            s1_v_q       <= s1_v_d;
            s1_op_q      <= s1_op_d;
            s1_sp_q      <= s1_sp_d;
            s1_unboxed_q <= s1_unboxed_d;
            s2_v_q       <= s2_v_d;
            s2_rec_q     <= s2_rec_d;
            s2_unboxed_q <= s2_unboxed_d;
`ifdef BP_FP_TO_REC_CLASS_EN
            s2_class_q   <= s2_class_d;
`endif
        end
    end

    assign bus.ready_o   = ready;
    assign bus.v_o       = s2_v_q;
    assign bus.rec_o     = s2_rec_q;
    assign bus.unboxed_o = s2_unboxed_q;
`ifdef BP_FP_TO_REC_CLASS_EN
    assign bus.class_o   = s2_class_q;
`endif
endmodule

// File: tb/tb_bp_be_fp_to_rec_pipe.sv
// Scoreboard bench for bp_be_fp_to_rec_pipe: value-based reference model, directed and random traffic.
// Checks class_o as well when BP_FP_TO_REC_CLASS_EN is defined.
module tb_bp_be_fp_to_rec_pipe;
    logic clk = 1'b0;
    logic rst_n;
    logic yumi_en;
    logic rnd_bp;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_pop  = 0;

    typedef struct {
        logic [64:0] rec;
        logic        unboxed;
        logic [9:0]  cls;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    bp_be_fp_to_rec_pipe_if bus();
    assign bus.yumi_i = yumi_en & bus.v_o;

    bp_be_fp_to_rec_pipe dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected recoding from the number's value: recoded exponent = true exponent + 2048
    function automatic exp_t model(input logic [63:0] raw, input logic sp);
        exp_t        r;
        logic [31:0] w;
        logic        s;
        int          e, emax, bias, p, t, bit_idx;
        logic [51:0] f;
        logic [11:0] re;
        w = (&raw[63:32]) ? raw[31:0] : 32'h7FC0_0000;
        if (sp) begin
            s = w[31]; e = int'(w[30:23]); emax = 255; bias = 127; f = {w[22:0], 29'd0};
        end else begin
            s = raw[63]; e = int'(raw[62:52]); emax = 2047; bias = 1023; f = raw[51:0];
        end
        if (e == emax) begin
            re = (f == 52'd0) ? 12'hC00 : 12'hE00;
            if (f == 52'd0) bit_idx = s ? 0 : 7;
            else            bit_idx = f[51] ? 9 : 8;
        end else if (e == 0 && f == 52'd0) begin
            re = 12'd0;
            bit_idx = s ? 3 : 4;
        end else if (e == 0) begin
            p = 0;
            for (int i = 0; i < 52; i++) if (f[i]) p = i;
            t  = p - 52 + 1 - bias;
            re = 12'(t + 2048);
            f  = f << (52 - p);
            bit_idx = s ? 2 : 5;
        end else begin
            re = 12'(e - bias + 2048);
            bit_idx = s ? 1 : 6;
        end
        r.rec     = {s, re, f};
        r.unboxed = sp & ~(&raw[63:32]);
        r.cls     = 10'd0;
        r.cls[bit_idx] = 1'b1;
        return r;
    endfunction

    // Scoreboard: compare every cycle v_o is up (also proves stability), pop on yumi, push on fire
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.v_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_v_o", 65'(bus.v_o), 65'd0);
                end else begin
                    chk("rec_o", bus.rec_o, sb[0].rec);
                    chk("unboxed_o", 65'(bus.unboxed_o), 65'(sb[0].unboxed));
`ifdef BP_FP_TO_REC_CLASS_EN
                    chk("class_o", 65'(bus.class_o), 65'(sb[0].cls));
`endif
                    if (bus.yumi_i) begin
                        void'(sb.pop_front());
                        n_pop++;
                    end
                end
            end
            if (bus.v_i && bus.ready_o) sb.push_back(model(bus.raw_i, bus.raw_sp_not_dp_i));
        end
    end

    // Called at posedge+1; holds v_i until the handshake fires
    task automatic send(input logic [63:0] raw, input logic sp);
        logic acc = 1'b0;
        int   n   = 0;
        bus.raw_i = raw;
        bus.raw_sp_not_dp_i = sp;
        bus.v_i = 1'b1;
        while (!acc && n < 60) begin
            @(negedge clk);
            acc = bus.ready_o;
            @(posedge clk); #1;
            if (rnd_bp) yumi_en = ($urandom_range(0, 3) != 0);
            n++;
        end
        bus.v_i = 1'b0;
        if (!acc) chk("send_timeout", 65'd0, 65'd1);
    endtask

    // Empty pipe, yumi enabled: checks 2-cycle latency and the exact recoded value
    task automatic send_check(input string tag, input logic [63:0] raw, input logic sp,
                              input logic [64:0] erec, input logic eunb, input logic [9:0] ecls);
        send(raw, sp);
        @(negedge clk);
        chk({tag, "_lat1"}, 65'(bus.v_o), 65'd0);
        @(negedge clk);
        chk({tag, "_v_o"}, 65'(bus.v_o), 65'd1);
        chk({tag, "_rec"}, bus.rec_o, erec);
        chk({tag, "_unb"}, 65'(bus.unboxed_o), 65'(eunb));
`ifdef BP_FP_TO_REC_CLASS_EN
        chk({tag, "_cls"}, 65'(bus.class_o), 65'(ecls));
`endif
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        yumi_en = 1'b1;
        for (int c = 0; c < 40 && sb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        repeat (2) begin @(posedge clk); #1; end
        chk(tag, 65'(sb.size()), 65'd0);
    endtask

    function automatic logic [63:0] rnd_op(input logic sp);
        logic [63:0] r;
        int          k;
        r = {$urandom, $urandom};
        k = int'($urandom_range(0, 4));
        if (sp) begin
            if (k == 0) r[30:23] = 8'h00;
            if (k == 1) r[30:23] = 8'hFF;
            if ($urandom_range(0, 7) != 0) r[63:32] = 32'hFFFF_FFFF;
        end else begin
            if (k == 0) r[62:52] = 11'h000;
            if (k == 1) r[62:52] = 11'h7FF;
        end
        return r;
    endfunction

    logic [63:0] dir_raw [18] = '{
        64'hFFFFFFFF_00000001, 64'hFFFFFFFF_007FFFFF, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_7F800000,
        64'hFFFFFFFF_FF800000, 64'hFFFFFFFF_7F800001, 64'hFFFFFFFF_7FC00001, 64'hFFFFFFFF_7F7FFFFF,
        64'hFFFFFFFE_3F800000, 64'hFFFFFFFF_00800000,
        64'h00000000_00000000, 64'h00000000_00000001, 64'h000FFFFF_FFFFFFFF, 64'h7FF00000_00000000,
        64'h7FF00000_00000001, 64'h7FF80000_00000000, 64'h7FEFFFFF_FFFFFFFF, 64'hBFF80000_00000000
    };
    logic dir_sp [18] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [63:0] bp_raw [4] = '{64'h3FF00000_00000000, 64'hC0100000_00000000,
                               64'h00000000_00000010, 64'h40490FDB_00000000};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic f;
        int   idx, acc, pops0;
        bus.v_i = 1'b0;
        bus.raw_i = '0;
        bus.raw_sp_not_dp_i = 1'b0;
        yumi_en = 1'b0;
        rnd_bp = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_v_o", 65'(bus.v_o), 65'd0);
        chk("reset_rec_o", bus.rec_o, 65'd0);
        chk("reset_unboxed_o", 65'(bus.unboxed_o), 65'd0);
`ifdef BP_FP_TO_REC_CLASS_EN
        chk("reset_class_o", 65'(bus.class_o), 65'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 65'(bus.ready_o), 65'd1);

        yumi_en = 1'b1;
        send_check("sp_one",     64'hFFFFFFFF_3F800000, 1'b1, 65'h0_8000_0000_0000_0000, 1'b0, 10'h040);
        send_check("sp_unboxed", 64'h00000000_3F800000, 1'b1, 65'h0_E008_0000_0000_0000, 1'b1, 10'h200);
        send_check("dp_two",     64'h40000000_00000000, 1'b0, 65'h0_8010_0000_0000_0000, 1'b0, 10'h040);
        send_check("dp_negzero", 64'h80000000_00000000, 1'b0, 65'h1_0000_0000_0000_0000, 1'b0, 10'h008);

        for (int i = 0; i < 18; i++) send(dir_raw[i], dir_sp[i]);
        drain("drain_directed");

        // Backpressure: only two operands fit while nothing is consumed
        yumi_en = 1'b0;
        idx = 0; acc = 0;
        bus.raw_i = bp_raw[0]; bus.raw_sp_not_dp_i = 1'b0; bus.v_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); f = bus.ready_o;
            @(posedge clk); #1;
            if (f) begin acc++; idx++; bus.raw_i = bp_raw[idx]; end
        end
        chk("bp_accepted", 65'(acc), 65'd2);
        @(negedge clk);
        chk("bp_ready_low", 65'(bus.ready_o), 65'd0);
        chk("bp_v_o", 65'(bus.v_o), 65'd1);
        @(posedge clk); #1;
        yumi_en = 1'b1;
        pops0 = n_pop;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); f = bus.ready_o;
            if (c == 0) chk("full_sim_ready", 65'(f), 65'd1);
            else        chk("drain_v_o", 65'(bus.v_o), 65'd1);
            @(posedge clk); #1;
            if (bus.v_i && f) begin
                idx++;
                if (idx < 4) bus.raw_i = bp_raw[idx];
                else         bus.v_i = 1'b0;
            end
        end
        chk("bp_all_accepted", 65'(idx), 65'd4);
        chk("drain_rate", 65'(n_pop - pops0), 65'd4);
        drain("drain_bp");

        rnd_bp = 1'b1;
        for (int i = 0; i < 150; i++) begin
            f = 1'($urandom_range(0, 1));
            send(rnd_op(f), f);
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk); #1;
                yumi_en = ($urandom_range(0, 3) != 0);
            end
        end
        rnd_bp = 1'b0;
        drain("drain_random");

        // Async reset with a valid result on the output
        yumi_en = 1'b0;
        send(64'h3FF00000_00000000, 1'b0);
        send(64'hFFFFFFFF_40400000, 1'b1);
        chk("pre_reset_v_o", 65'(bus.v_o), 65'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_v_o", 65'(bus.v_o), 65'd0);
        chk("async_rec_o", bus.rec_o, 65'd0);
        chk("async_unboxed_o", 65'(bus.unboxed_o), 65'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        yumi_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_emit_after_reset", 65'(bus.v_o), 65'd0);
        end
        chk("ready_post_flush", 65'(bus.ready_o), 65'd1);
        @(posedge clk); #1;
        send_check("post_reset", 64'h40000000_00000000, 1'b0, 65'h0_8010_0000_0000_0000, 1'b0, 10'h040);
        drain("drain_final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bp_be_fp_to_rec_pipe.md
Name: bp_be_fp_to_rec_pipe

Overview:
- Converts a 64-bit raw IEEE-754 register value (SP or DP) into 65-bit DP-recoded HardFloat format for the FPU.
- Handles RISC-V NaN-boxing: an SP value whose upper 32 bits are not all ones is replaced by the canonical NaN.
- Two-stage valid/ready pipeline between the FP register-file read and the FMA/aux recoded-operand inputs.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config; supplies dword_width_p (64) and dp_rec_width_gp (65).
- sp_exp_width_gp, 8, SP exponent width (package constant).
- sp_sig_width_gp, 24, SP significand width incl. hidden bit.
- dp_exp_width_gp, 11, DP exponent width.
- dp_sig_width_gp, 53, DP significand width incl. hidden bit.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- raw_i  in  64  raw IEEE operand
- raw_sp_not_dp_i  in  1  1 = SP in raw_i[31:0] (NaN-boxed), 0 = DP
- v_i  in  1  input valid
- ready_o  out  1  input ready
- rec_o  out  65  DP-recoded result
- unboxed_o  out  1  SP input failed the NaN-box check (canonical NaN substituted)
- v_o  out  1  output valid
- yumi_i  in  1  consumer accepts rec_o this cycle; legal only when v_o=1

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset_n_i=0, asynchronous): both stage valids=0, v_o=0, rec_o=0, unboxed_o=0. ready_o=1 one cycle after reset deasserts.
- Stage valids: s1_v, s2_v.
- Stage 1 capture:
  - Input handshake fires on v_i & ready_o.
  - On fire, s1 stores raw_i, sp flag, and boxed = &raw_i[63:32].
  - SP with boxed=0: s1 operand becomes SP canonical NaN 0x7FC00000 and unboxed flag is set.
- Stage 2 recode:
  - SP: run fNToRecFN(8,24) on the 32-bit operand to get a 33-bit SP-recoded value, then widen to DP-recoded.
    - code = sp_exp[8:6].
    - special (code==000 or code>=110): dp_exp = {code, 3'b000, sp_exp[5:0]}.
    - else: dp_exp = sp_exp + 12'd1792 (2^11 - 2^8), zero-extended.
    - dp_fract = sp_fract << 29.
    - sign passes through.
  - DP: run fNToRecFN(11,53) directly.
  - Widening is exact. A DP->SP round trip through the existing rec-to-raw path returns the original SP bits.
- Flow control:
  - s2 loads when s1_v & (~s2_v | yumi_i).
  - s1 loads when the input handshake fires; s1_v clears when s1 advances without a new input.
  - ready_o = ~s1_v | ~s2_v | yumi_i. Combinational from yumi_i only, not from v_i.
- Latency: 2 cycles from input handshake to v_o with no backpressure. Throughput: 1 per cycle.
- Full condition: both stages valid and yumi_i=0 → ready_o=0 and all registers hold.
- Simultaneous input fire and yumi_i on a full pipe: all three happen in the same cycle with no bubble — s2 emits, s1 moves to s2, input enters s1.
- Data stability: rec_o and unboxed_o hold while v_o=1 and yumi_i=0.
- Reset mid-operation flushes all in-flight data; nothing is emitted afterwards.
- No exception flags; the conversion is exact.

Optional Feature:
- Macro: BP_FP_TO_REC_CLASS_EN.
- Defined:
  - Extra output port class_o, 10 bits, registered in s2 alongside rec_o.
  - Encoding is RISC-V fclass: bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0, bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf, bit8 sNaN, bit9 qNaN.
  - Classified from the post-box-check operand at its own precision. Exactly one bit is set when v_o=1; reset value is 0.
- Undefined: port is absent and no classification logic is built.

Test Plan:
- SP boxed 1.0: raw_i=64'hFFFFFFFF_3F800000, sp=1 → two cycles later rec_o=65'h0_8000_0000_0000_0000, unboxed_o=0.
- SP unboxed: raw_i=64'h00000000_3F800000, sp=1 → rec_o=65'h0_E008_0000_0000_0000 (canonical NaN), unboxed_o=1; with the macro, class_o=10'h200.
- DP values:
  - raw_i=64'h4000000000000000, sp=0 → rec_o=65'h0_8010_0000_0000_0000.
  - raw_i=64'h8000000000000000, sp=0 → rec_o=65'h1_0000_0000_0000_0000.
- Backpressure:
  - Stream 4 operands with v_i=1 while yumi_i=0 → ready_o drops after 2 accepted.
  - Raise yumi_i → results emerge in order, no loss or duplication, one per cycle.
- Full-pipe simultaneous: both stages valid, v_i=1 and yumi_i=1 in the same cycle → output, shift, and input all occur that cycle; v_o remains 1.
- Async reset mid-stream: assert reset_n_i between clock edges while v_o=1 → v_o and rec_o go to 0 immediately; the next accepted input appears 2 cycles after its handshake.
